// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit memory master:
//   - RV32I load/store funct3 encodings
//   - FSM state enumeration
//   - size_from_funct3 : access size in bytes (0 marks an unsupported encoding)
//   - lsu_is_illegal   : funct3/direction combinations rejected without traffic
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_e;

  // Bytes touched by an access; 0 for encodings that have no size.
  function automatic logic [2:0] size_from_funct3(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default:     size = 3'd0;
    endcase
    return size;
  endfunction

  // 011/110/111 have no size; unsigned variants only exist for loads.
  function automatic logic lsu_is_illegal(input logic we, input logic [2:0] funct3);
    return (size_from_funct3(funct3) == 3'd0) || (we && funct3[2]);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane formatting for the LSU.
// Store side:
//   st_off_i   byte offset within the word (addr[1:0])
//   st_size_i  access size in bytes (1, 2 or 4)
//   st_wdata_i right-justified store data
//   be64_o     byte enables across two consecutive words (low nibble = beat 0)
//   wd64_o     write data across two consecutive words (low word = beat 0)
// Load side:
//   ld_off_i    byte offset of the load
//   ld_funct3_i funct3 of the load (size and sign)
//   ld_words_i  {word1, word0} as returned by memory
//   ld_data_o   right-justified, sign/zero-extended load result
// -----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [2:0]  st_size_i,
  input  logic [31:0] st_wdata_i,
  output logic [7:0]  be64_o,
  output logic [63:0] wd64_o,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [63:0] ld_words_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  be_base;
  logic [31:0] ld_win;

  always_comb begin
    case (st_size_i)
      3'd1:    be_base = 8'h01;
      3'd2:    be_base = 8'h03;
      3'd4:    be_base = 8'h0F;
      default: be_base = 8'h00;
    endcase
    be64_o = be_base << st_off_i;
    wd64_o = {32'h0, st_wdata_i} << {st_off_i, 3'b000};
  end

  // The addressed byte sits at bit 8*off of the two-word window; a 32-bit
  // slice from there covers every legal access, including split ones.
  assign ld_win = ld_words_i[{ld_off_i, 3'b000} +: 32];

  always_comb begin
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_win[7]}}, ld_win[7:0]};
      F3_BU:   ld_data_o = {24'h0, ld_win[7:0]};
      F3_H:    ld_data_o = {{16{ld_win[15]}}, ld_win[15:0]};
      F3_HU:   ld_data_o = {16'h0, ld_win[15:0]};
      default: ld_data_o = ld_win;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Load/store initiator between the execute stage and a word-organised memory
// port with a req/gnt/rvalid handshake. Word-crossing accesses are issued as
// two word beats; load data is merged and extended before a one-cycle
// response pulse.
// Core side:
//   req_valid/req_ready  access handshake (ready only while idle)
//   req_we, req_funct3   direction and RV32I size/sign encoding
//   req_addr, req_wdata  byte address and right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores and errors)
//   resp_err             illegal funct3, qualified by resp_valid
// Memory side:
//   mem_req/mem_gnt      request held with stable fields until granted
//   mem_we, mem_addr     write strobe and word-aligned address
//   mem_be, mem_wdata    byte enables and lane-aligned write data
//   mem_rvalid/mem_rdata one read beat per granted load request
// -----------------------------------------------------------------------------
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e state_q;

  // Latched access
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic                  split_q;
  logic [ADDR_WIDTH-1:2] addr1_q;
  logic [3:0]            be1_q;
  logic [DATA_WIDTH-1:0] wd1_q;
  logic [DATA_WIDTH-1:0] word0_q;

  // Registered outputs
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  // Accept-time decode, taken straight from the request inputs so that beat 0
  // can be registered onto the memory port at the accept edge.
  logic [2:0]            acc_size;
  logic                  acc_split;
  logic                  acc_illegal;
  logic [ADDR_WIDTH-1:0] acc_addr0;
  logic [7:0]            be64;
  logic [63:0]           wd64;
  logic [63:0]           ld_words;
  logic [31:0]           ld_data;

  assign acc_size    = size_from_funct3(req_funct3);
  assign acc_split   = ({1'b0, req_addr[1:0]} + acc_size) > 3'd4;
  assign acc_illegal = lsu_is_illegal(req_we, req_funct3);
  assign acc_addr0   = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  // The final beat is merged straight from the bus so the response can be
  // registered in the same edge that captures it.
  assign ld_words = (state_q == ST_WAIT1) ? {mem_rdata, word0_q} : {32'h0, mem_rdata};

  lsu_lane_align u_lane_align (
    .st_off_i    (req_addr[1:0]),
    .st_size_i   (acc_size),
    .st_wdata_i  (req_wdata),
    .be64_o      (be64),
    .wd64_o      (wd64),
    .ld_off_i    (off_q),
    .ld_funct3_i (funct3_q),
    .ld_words_i  (ld_words),
    .ld_data_o   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      split_q      <= 1'b0;
      addr1_q      <= '0;
      be1_q        <= 4'h0;
      wd1_q        <= '0;
      word0_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= '0;
    end else begin
      // Response outputs are a pulse: only the edge entering RESP sets them.
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;

      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            off_q       <= req_addr[1:0];
            split_q     <= acc_split;
            addr1_q     <= req_addr[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1);
            be1_q       <= be64[7:4];
            wd1_q       <= wd64[63:32];
            req_ready_q <= 1'b0;
            if (acc_illegal) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q     <= ST_REQ0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= acc_addr0;
              mem_be_q    <= be64[3:0];
              mem_wdata_q <= wd64[31:0];
            end
          end
        end

        ST_REQ0: begin
          if (mem_gnt) begin
            if (we_q && split_q) begin
              // Store second beat follows directly; no read data to wait for.
              state_q     <= ST_REQ1;
              mem_addr_q  <= {addr1_q, 2'b00};
              mem_be_q    <= be1_q;
              mem_wdata_q <= wd1_q;
            end else begin
              mem_req_q   <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= '0;
              mem_be_q    <= 4'h0;
              mem_wdata_q <= '0;
              if (we_q) begin
                state_q      <= ST_RESP;
                resp_valid_q <= 1'b1;
              end else begin
                state_q <= ST_WAIT0;
              end
            end
          end
        end

        ST_WAIT0: begin
          if (mem_rvalid) begin
            word0_q <= mem_rdata;
            if (split_q) begin
              state_q     <= ST_REQ1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {addr1_q, 2'b00};
              mem_be_q    <= be1_q;
              mem_wdata_q <= wd1_q;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= ld_data;
            end
          end
        end

        ST_REQ1: begin
          if (mem_gnt) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= '0;
            if (we_q) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT1;
            end
          end
        end

        ST_WAIT1: begin
          if (mem_rvalid) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ld_data;
          end
        end

        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_be_q    <= 4'h0;
          mem_wdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
// Directed bench for lsu_mem_master. run_access drives one core access and
// plays a simple memory (configurable grant delay, read beat one cycle after
// each granted load), recording every granted beat and the response.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_access
  int          nbeats;
  logic [31:0] b_addr  [4];
  logic [31:0] b_first [4];
  logic [3:0]  b_be    [4];
  logic [31:0] b_wd    [4];
  logic        b_we    [4];
  logic [31:0] rd_words[2];
  int          lat;
  logic [31:0] got_rdata;
  logic        got_err;

  // Starts and ends on a falling edge. lat counts rising edges from the accept
  // edge (inclusive) to the one after which resp_valid is high.
  task automatic run_access(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int gnt_wait);
    int  c;
    int  held;
    int  widx;
    bit  rv_pend;
    bit  done;
    nbeats = 0; lat = -1; got_rdata = 32'h0; got_err = 1'b0;
    held = 0; widx = 0; rv_pend = 1'b0; done = 1'b0; c = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    while (!done && c < 40) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      req_valid = 1'b0;
      if (c == 1) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL req_ready_busy: got %b expected 0", req_ready);
        end
      end
      if (resp_valid === 1'b1) begin
        done = 1'b1; lat = c; got_rdata = resp_rdata; got_err = resp_err;
      end
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (rv_pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (widx < 2) ? rd_words[widx] : 32'hBAD0BAD0;
        widx++;
        rv_pend = 1'b0;
      end
      mem_gnt = 1'b0;
      if (mem_req === 1'b1) begin
        if (held == 0 && nbeats < 4) b_first[nbeats] = mem_addr;
        if (held >= gnt_wait) begin
          mem_gnt = 1'b1;
          if (nbeats < 4) begin
            b_addr[nbeats] = mem_addr; b_be[nbeats] = mem_be;
            b_wd[nbeats] = mem_wdata;  b_we[nbeats] = mem_we;
          end
          nbeats++;
          if (mem_we !== 1'b1) rv_pend = 1'b1;
          held = 0;
        end else begin
          held++;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL resp_timeout: got no resp_valid in %0d cycles, expected one", c);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_pulse: got resp_valid=%b req_ready=%b expected 0/1", resp_valid, req_ready);
    end
    $display("access we=%0b f3=%03b addr=%08h wdata=%08h -> lat=%0d beats=%0d rdata=%08h err=%0b",
             we, f3, addr, wdata, lat, nbeats, got_rdata, got_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/rv/err/req/we=%b expected 10000",
               {req_ready, resp_valid, resp_err, mem_req, mem_we});
    end
    checks++;
    if ({resp_rdata, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h be=%b expected all 0",
               resp_rdata, mem_addr, mem_wdata, mem_be);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw_aligned();
    rd_words[0] = 32'hDEADBEEF; rd_words[1] = 32'h0;
    run_access(1'b0, F3_W, 32'h0000_1000, 32'h0, 0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lw_lat: got %0d expected 3", lat); end
    checks++; if (nbeats !== 1) begin errors++; $display("FAIL lw_beats: got %0d expected 1", nbeats); end
    checks++; if (b_addr[0] !== 32'h1000) begin errors++; $display("FAIL lw_addr: got %h expected 00001000", b_addr[0]); end
    checks++; if (b_be[0] !== 4'b1111 || b_we[0] !== 1'b0) begin errors++; $display("FAIL lw_be_we: got be=%b we=%b expected 1111/0", b_be[0], b_we[0]); end
    checks++; if (got_rdata !== 32'hDEADBEEF || got_err !== 1'b0) begin errors++; $display("FAIL lw_data: got %h err=%b expected deadbeef err=0", got_rdata, got_err); end
  endtask

  task automatic test_byte_half_loads();
    rd_words[0] = 32'h80FF_FFFF;
    run_access(1'b0, F3_B, 32'h0000_1003, 32'h0, 0);
    checks++; if (b_be[0] !== 4'b1000 || b_addr[0] !== 32'h1000) begin errors++; $display("FAIL lb_beat: got be=%b addr=%h expected 1000/00001000", b_be[0], b_addr[0]); end
    checks++; if (got_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", got_rdata); end
    run_access(1'b0, F3_BU, 32'h0000_1003, 32'h0, 0);
    checks++; if (got_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", got_rdata); end
    rd_words[0] = 32'h80FF_1234;
    run_access(1'b0, F3_H, 32'h0000_1002, 32'h0, 0);
    checks++; if (b_be[0] !== 4'b1100 || nbeats !== 1) begin errors++; $display("FAIL lh_beat: got be=%b beats=%0d expected 1100/1", b_be[0], nbeats); end
    checks++; if (got_rdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_data: got %h expected ffff80ff", got_rdata); end
    run_access(1'b0, F3_HU, 32'h0000_1002, 32'h0, 0);
    checks++; if (got_rdata !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_data: got %h expected 000080ff", got_rdata); end
  endtask

  task automatic test_store_half();
    run_access(1'b1, F3_H, 32'h0000_1002, 32'h0000_ABCD, 0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sh_lat: got %0d expected 2", lat); end
    checks++; if (nbeats !== 1) begin errors++; $display("FAIL sh_beats: got %0d expected 1", nbeats); end
    checks++; if (b_addr[0] !== 32'h1000 || b_be[0] !== 4'b1100) begin errors++; $display("FAIL sh_beat: got addr=%h be=%b expected 00001000/1100", b_addr[0], b_be[0]); end
    checks++; if (b_wd[0] !== 32'hABCD_0000 || b_we[0] !== 1'b1) begin errors++; $display("FAIL sh_wdata: got %h we=%b expected abcd0000/1", b_wd[0], b_we[0]); end
    checks++; if (got_rdata !== 32'h0 || got_err !== 1'b0) begin errors++; $display("FAIL sh_resp: got rdata=%h err=%b expected 0/0", got_rdata, got_err); end
  endtask

  task automatic test_split_load();
    rd_words[0] = 32'h1122_3344; rd_words[1] = 32'h5566_7788;
    run_access(1'b0, F3_W, 32'h0000_1003, 32'h0, 0);
    checks++; if (lat !== 5) begin errors++; $display("FAIL split_lw_lat: got %0d expected 5", lat); end
    checks++; if (nbeats !== 2) begin errors++; $display("FAIL split_lw_beats: got %0d expected 2", nbeats); end
    checks++; if (b_addr[0] !== 32'h1000 || b_be[0] !== 4'b1000) begin errors++; $display("FAIL split_lw_b0: got addr=%h be=%b expected 00001000/1000", b_addr[0], b_be[0]); end
    checks++; if (b_addr[1] !== 32'h1004 || b_be[1] !== 4'b0111) begin errors++; $display("FAIL split_lw_b1: got addr=%h be=%b expected 00001004/0111", b_addr[1], b_be[1]); end
    checks++; if (got_rdata !== 32'h6677_8811) begin errors++; $display("FAIL split_lw_data: got %h expected 66778811", got_rdata); end
  endtask

  task automatic test_split_store();
    run_access(1'b1, F3_W, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 0);
    checks++; if (lat !== 3 || nbeats !== 2) begin errors++; $display("FAIL split_sw_lat: got lat=%0d beats=%0d expected 3/2", lat, nbeats); end
    checks++; if (b_addr[0] !== 32'hFFFF_FFFC || b_be[0] !== 4'b1100 || b_wd[0] !== 32'hC3D4_0000) begin errors++; $display("FAIL split_sw_b0: got addr=%h be=%b wd=%h expected fffffffc/1100/c3d40000", b_addr[0], b_be[0], b_wd[0]); end
    checks++; if (b_addr[1] !== 32'h0000_0000 || b_be[1] !== 4'b0011 || b_wd[1] !== 32'h0000_A1B2) begin errors++; $display("FAIL split_sw_b1: got addr=%h be=%b wd=%h expected 00000000/0011/0000a1b2", b_addr[1], b_be[1], b_wd[1]); end
    checks++; if (b_we[0] !== 1'b1 || b_we[1] !== 1'b1) begin errors++; $display("FAIL split_sw_we: got %b%b expected 11", b_we[0], b_we[1]); end
  endtask

  task automatic test_illegal();
    run_access(1'b0, 3'b011, 32'h0000_1000, 32'h0, 0);
    checks++; if (nbeats !== 0) begin errors++; $display("FAIL ill_load_traffic: got %0d beats expected 0", nbeats); end
    checks++; if (got_err !== 1'b1 || got_rdata !== 32'h0) begin errors++; $display("FAIL ill_load_resp: got err=%b rdata=%h expected 1/0", got_err, got_rdata); end
    checks++; if (lat < 1 || lat > 2) begin errors++; $display("FAIL ill_load_lat: got %0d expected 1..2", lat); end
    run_access(1'b1, F3_BU, 32'h0000_1000, 32'h55, 0);
    checks++; if (nbeats !== 0 || got_err !== 1'b1) begin errors++; $display("FAIL ill_store: got beats=%0d err=%b expected 0/1", nbeats, got_err); end
    run_access(1'b0, 3'b110, 32'h0000_1000, 32'h0, 0);
    checks++; if (nbeats !== 0 || got_err !== 1'b1) begin errors++; $display("FAIL ill_f3_110: got beats=%0d err=%b expected 0/1", nbeats, got_err); end
  endtask

  task automatic test_gnt_stall();
    rd_words[0] = 32'h0BAD_F00D;
    run_access(1'b0, F3_W, 32'h0000_2000, 32'h0, 3);
    checks++; if (lat !== 6) begin errors++; $display("FAIL stall_lat: got %0d expected 6", lat); end
    checks++; if (b_first[0] !== 32'h2000 || b_addr[0] !== 32'h2000) begin errors++; $display("FAIL stall_addr_hold: got first=%h at_gnt=%h expected 00002000", b_first[0], b_addr[0]); end
    checks++; if (got_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL stall_data: got %h expected 0badf00d", got_rdata); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, F3_B, 32'h0000_1001, 32'h0000_005A, 0);
    checks++; if (b_be[0] !== 4'b0010 || b_wd[0] !== 32'h0000_5A00 || lat !== 2) begin errors++; $display("FAIL b2b_sb: got be=%b wd=%h lat=%0d expected 0010/00005a00/2", b_be[0], b_wd[0], lat); end
    rd_words[0] = 32'h0000_5A00;
    run_access(1'b0, F3_BU, 32'h0000_1001, 32'h0, 0);
    checks++; if (got_rdata !== 32'h0000_005A || lat !== 3) begin errors++; $display("FAIL b2b_lbu: got %h lat=%0d expected 0000005a/3", got_rdata, lat); end
    run_access(1'b1, F3_W, 32'h0000_1004, 32'h1357_9BDF, 0);
    checks++; if (b_addr[0] !== 32'h1004 || b_be[0] !== 4'b1111 || b_wd[0] !== 32'h1357_9BDF) begin errors++; $display("FAIL b2b_sw: got addr=%h be=%b wd=%h expected 00001004/1111/13579bdf", b_addr[0], b_be[0], b_wd[0]); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h0000_3000; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req0: got mem_req=%b expected 1", mem_req); end
    mem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_wait0: got mem_req=%b req_ready=%b expected 0/0", mem_req, req_ready); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we} !== 5'b10000 ||
        {resp_rdata, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
      errors++;
      $display("FAIL mid_reset_vals: got ready/rv/err/req/we=%b rdata=%h addr=%h be=%b expected 10000 and zeros",
               {req_ready, resp_valid, resp_err, mem_req, mem_we}, resp_rdata, mem_addr, mem_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      checks++;
      if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL mid_stray_rvalid: got rv=%b req=%b ready=%b expected 0/0/1", resp_valid, mem_req, req_ready);
      end
    end
    rd_words[0] = 32'hCAFE_0001;
    run_access(1'b0, F3_W, 32'h0000_3000, 32'h0, 0);
    checks++; if (got_rdata !== 32'hCAFE_0001 || lat !== 3) begin errors++; $display("FAIL mid_recover: got %h lat=%0d expected cafe0001/3", got_rdata, lat); end
  endtask

  initial begin
    test_reset();
    test_lw_aligned();
    test_byte_half_loads();
    test_store_half();
    test_split_load();
    test_split_store();
    test_illegal();
    test_gnt_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
